ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Serialises a parallel bitstream into a configuration flip-flop (ccff) shift
// chain, LSB of each word first, and can optionally read the chain back by
// looping its tail onto its head. A loop-back pass rotates the chain all the
// way round, so its contents are unchanged afterwards. A CRC-8 of the bits
// that were sent is compared with a CRC-8 of the bits that came back.
//
// Ports
//   prog_clk      programming clock, all state updates on its rising edge
//   pReset        asynchronous active-high programming reset
//   start         one-cycle load request, only looked at while idle
//   verify_en     request a loop-back readback after the load (taken with start)
//   cfg_data      bitstream word, sent LSB first
//   cfg_valid     cfg_data is valid
//   cfg_ready     this block takes cfg_data this cycle
//   ccff_head     serial data into the chain head
//   ccff_tail     serial data coming out of the chain tail
//   chain_clk_en  registered enable for the external prog_clk gate; the chain
//                 shifts on the next prog_clk edge only while it is high
//   busy          high whenever the block is not idle
//   done          one-cycle completion pulse
//   readback_err  loop-back CRC mismatch, held until the next accepted start
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              busy,
   output logic              done,
   output logic              readback_err
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int REM_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      FIN
   } state_t;

   state_t state;
   state_t state_nxt;

   // One-word buffer; buf_rem counts how many of its bits still have to go out
   logic [WORD_W-1:0] buf_data;
   logic [REM_W-1:0]  buf_rem;

   // acc_cnt: chain bits covered by accepted words; tx_cnt: bits sent;
   // rx_cnt: bits read back during loop-back
   logic [CNT_W-1:0]  acc_cnt;
   logic [CNT_W-1:0]  tx_cnt;
   logic [CNT_W-1:0]  rx_cnt;
   logic [CNT_W-1:0]  need_bits;

   logic [7:0]        tx_crc;
   logic [7:0]        rx_crc;
   logic              verify_q;
   logic              ccff_head_q;

   logic              bit_avail;
   logic              accept;
   logic              all_accepted;
   logic              word_full;
   logic              tx_done;
   logic              rx_last;
   logic              clk_en_nxt;

   // CRC-8, polynomial x^8 + x^2 + x + 1 (0x07), one input bit per step
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb        = crc[7] ^ din;
      crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   // Bits still owed to the chain. When fewer than a full word remain, only
   // that many low bits of the next word are used and the rest are dropped.
   assign need_bits    = CNT_W'(CHAIN_LEN) - acc_cnt;
   assign word_full    = (32'(need_bits) >= 32'(WORD_W));
   assign all_accepted = (acc_cnt == CNT_W'(CHAIN_LEN));
   assign tx_done      = (tx_cnt == CNT_W'(CHAIN_LEN));
   assign rx_last      = (rx_cnt == CNT_W'(CHAIN_LEN - 1));

   // State register. A reset anywhere drops straight back to IDLE, so an
   // interrupted load never gives a done pulse.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and combinational outputs.
   // cfg_ready also goes high while the buffer's last bit is being sent, so
   // back-to-back words stream with no bubble. The bit registered on the
   // final LOAD cycle is shifted in one cycle later, so LOAD keeps one extra
   // cycle (tx_done) with the enable still high before moving on. On that
   // cycle the enable stays high when going into VERIFY and drops for FIN.
   always_comb begin
      state_nxt  = state;
      cfg_ready  = 1'b0;
      bit_avail  = 1'b0;
      accept     = 1'b0;
      clk_en_nxt = 1'b0;
      busy       = (state != IDLE);
      done       = (state == FIN);
      ccff_head  = ccff_head_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            bit_avail = (buf_rem != '0);
            cfg_ready = !all_accepted && ((buf_rem == '0) || (buf_rem == REM_W'(1)));
            accept    = cfg_valid && cfg_ready;
            if (tx_done) begin
               state_nxt  = verify_q ? VERIFY : FIN;
               clk_en_nxt = verify_q;
            end else begin
               clk_en_nxt = bit_avail;
            end
         end
         VERIFY: begin
            ccff_head = ccff_tail;
            if (rx_last) begin
               state_nxt = FIN;
            end else begin
               clk_en_nxt = 1'b1;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: buffer, head register, counters and CRCs.
   // When a word is accepted in the same cycle the previous one sends its
   // last bit, that last bit is read from buf_data before it is replaced.
   // During loop-back, every tail bit is folded into rx_crc. The mismatch
   // flag is set on the last loop-back cycle, including that cycle's bit.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         buf_data     <= '0;
         buf_rem      <= '0;
         acc_cnt      <= '0;
         tx_cnt       <= '0;
         rx_cnt       <= '0;
         tx_crc       <= '0;
         rx_crc       <= '0;
         verify_q     <= 1'b0;
         ccff_head_q  <= 1'b0;
         chain_clk_en <= 1'b0;
         readback_err <= 1'b0;
      end else begin
         chain_clk_en <= clk_en_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  buf_rem      <= '0;
                  acc_cnt      <= '0;
                  tx_cnt       <= '0;
                  rx_cnt       <= '0;
                  tx_crc       <= '0;
                  rx_crc       <= '0;
                  verify_q     <= verify_en;
                  readback_err <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  buf_data <= cfg_data;
                  if (word_full) begin
                     buf_rem <= REM_W'(WORD_W);
                     acc_cnt <= acc_cnt + CNT_W'(WORD_W);
                  end else begin
                     buf_rem <= REM_W'(need_bits);
                     acc_cnt <= CNT_W'(CHAIN_LEN);
                  end
               end else if (bit_avail) begin
                  buf_data <= buf_data >> 1;
                  buf_rem  <= buf_rem - REM_W'(1);
               end
               if (bit_avail) begin
                  ccff_head_q <= buf_data[0];
                  tx_crc      <= crc8_step(tx_crc, buf_data[0]);
                  tx_cnt      <= tx_cnt + CNT_W'(1);
               end
            end
            VERIFY: begin
               rx_crc <= crc8_step(rx_crc, ccff_tail);
               rx_cnt <= rx_cnt + CNT_W'(1);
               if (rx_last) begin
                  readback_err <= (crc8_step(rx_crc, ccff_tail) != tx_crc);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
